// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, exception codes, FSM states.
package dm_access_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/dm_access_unit_lane_merge.sv
// Little-endian lane handling: load extraction with sign/zero extension and sub-word store merge.
// Purely combinational, zero latency, no flow control.
module dm_lane_merge
  import dm_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      SZ_B:    load_data = {{24{sign & lane_b[7]}}, lane_b};
      SZ_H:    load_data = {{16{sign & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase

    // Untouched bytes keep the value read from memory.
    merged = word;
    case (size)
      SZ_B: begin
        case (addr_lo)
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store initiator for a word-only data memory; sub-word stores run as read-modify-write.
// Latency accept->rsp_valid: exception 1, load 2, word store 2, sub-word store 3; response held until rsp_ready.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int          MEM_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_exc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic        exc_illegal;
  logic        exc_misalign;
  logic        exc_range;
  logic        req_exc;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    exc_illegal  = (req_size == 2'b11);
    exc_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    exc_range    = (req_addr < ADDR_BASE) || ((req_addr - ADDR_BASE) >= MEM_BYTES);
    req_exc      = exc_illegal || exc_misalign || exc_range;
  end

  dm_lane_merge u_lane_merge (
    .word      (mem_rdata),
    .addr_lo   (addr_lo_q),
    .size      (size_q),
    .sign      (sign_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  // Gated so that a reset arriving during the write cycle never commits it.
  assign mem_we    = (state == ST_WR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      sign_q    <= 1'b0;
      addr_lo_q <= 2'b00;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_exc   <= EXC_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            sign_q    <= req_sign;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            if (req_exc) begin
              rsp_exc <= req_we ? EXC_ADES : EXC_ADEL;
              state   <= ST_RESP;
            end else begin
              rsp_exc  <= EXC_NONE;
              mem_addr <= {req_addr[31:2], 2'b00};
              mem_pc   <= req_pc;
              if (req_we && (req_size == SZ_W)) begin
                mem_wdata <= req_wdata;
                state     <= ST_WR;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (we_q) begin
            mem_wdata <= merged;
            state     <= ST_WR;
          end else begin
            rsp_rdata <= load_data;
            state     <= ST_RESP;
          end
        end
        ST_WR: state <= ST_RESP;
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed test of dm_access_unit against a behavioural word memory.
module tb_dm_access_unit;
  import dm_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_exc;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:3071];
  logic        pre_en = 1'b0;
  logic [11:0] pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          we_cnt = 0;
  logic [31:0] we_addr, we_data, we_pc;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_pc(mem_pc),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'h3000) ? mem[mem_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 32'h3000) mem[mem_addr[13:2]] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
      we_pc   <= mem_pc;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic [11:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request, wait (bounded) for the response, check it, then complete the handshake.
  task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic sign,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata,
                      input logic [4:0] exp_exc, input int exp_we);
    int lat;
    @(negedge clk);
    we_cnt = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata; req_pc = 32'h0040_0000 + addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, rsp_rdata, exp_rdata);
    chk({tag, " exc"}, {27'd0, rsp_exc}, {27'd0, exp_exc});
    chk({tag, " writes"}, 32'(we_cnt), 32'(exp_we));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_pc", mem_pc, 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    xfer("sw 0x10", 1'b1, SZ_W, 1'b0, 32'h10, 32'h1234_5678, 2, 32'h0, EXC_NONE, 1);
    chk("sw 0x10 addr", we_addr, 32'h10);
    chk("sw 0x10 data", we_data, 32'h1234_5678);
    chk("sw 0x10 pc", we_pc, 32'h0040_0010);

    preset(12'd4, 32'hAABB_CCDD);
    xfer("sb 0x12", 1'b1, SZ_B, 1'b0, 32'h12, 32'h0000_0011, 3, 32'h0, EXC_NONE, 1);
    chk("sb 0x12 addr", we_addr, 32'h10);
    chk("sb 0x12 data", we_data, 32'hAA11_CCDD);
    chk("sb 0x12 mem", mem[4], 32'hAA11_CCDD);

    preset(12'd5, 32'h5566_7788);
    xfer("sh 0x16", 1'b1, SZ_H, 1'b0, 32'h16, 32'hFFFF_BEEF, 3, 32'h0, EXC_NONE, 1);
    chk("sh 0x16 mem", mem[5], 32'hBEEF_7788);

    preset(12'd8, 32'h8070_F0FF);
    xfer("lb 0x21",  1'b0, SZ_B, 1'b1, 32'h21, 32'h0, 2, 32'hFFFF_FFF0, EXC_NONE, 0);
    xfer("lbu 0x21", 1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 2, 32'h0000_00F0, EXC_NONE, 0);
    xfer("lb 0x20",  1'b0, SZ_B, 1'b1, 32'h20, 32'h0, 2, 32'hFFFF_FFFF, EXC_NONE, 0);
    xfer("lbu 0x23", 1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 2, 32'h0000_0080, EXC_NONE, 0);
    xfer("lh 0x22",  1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 2, 32'hFFFF_8070, EXC_NONE, 0);
    xfer("lhu 0x22", 1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 2, 32'h0000_8070, EXC_NONE, 0);
    xfer("lh 0x20",  1'b0, SZ_H, 1'b1, 32'h20, 32'h0, 2, 32'hFFFF_F0FF, EXC_NONE, 0);
    xfer("lw 0x20",  1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 2, 32'h8070_F0FF, EXC_NONE, 0);

    xfer("lw 0x2",     1'b0, SZ_W,  1'b0, 32'h2,    32'h0, 1, 32'h0, EXC_ADEL, 0);
    xfer("sh 0x3",     1'b1, SZ_H,  1'b0, 32'h3,    32'h0, 1, 32'h0, EXC_ADES, 0);
    xfer("sw 0x3000",  1'b1, SZ_W,  1'b0, 32'h3000, 32'h0, 1, 32'h0, EXC_ADES, 0);
    xfer("lb 0x2FFF",  1'b0, SZ_B,  1'b0, 32'h2FFF, 32'h0, 2, 32'h0, EXC_NONE, 0);
    xfer("size11 ld",  1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 1, 32'h0, EXC_ADEL, 0);

    // Backpressure: response held, a waiting request must not be taken until after the handshake.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_sign = 1'b0; req_addr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp hold%0d rdata", i), rsp_rdata, 32'h8070_F0FF);
      chk($sformatf("bp hold%0d ready", i), {31'd0, req_ready}, 32'd0);
    end
    req_addr = 32'h10;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp idle after hs", {31'd0, req_ready}, 32'd1);
    chk("bp rsp dropped", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp next accepted", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp next rsp", {31'd0, rsp_valid}, 32'd1);
    chk("bp next rdata", rsp_rdata, 32'hAA11_CCDD);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during the RD cycle of a read-modify-write must leave memory untouched.
    preset(12'd5, 32'h5566_7788);
    @(negedge clk);
    we_cnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_addr = 32'h14; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw in RD", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rmw rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rmw rst req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmw rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmw rst writes", 32'(we_cnt), 32'd0);
    chk("rmw rst mem", mem[5], 32'h5566_7788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
